// File: rtl/rom_stream_loader_pkg.sv
// Shared definitions for the boot-time ROM stream loader: FSM state encoding,
// default frame start byte and the checksum helper.
package rom_stream_loader_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN0  = 3'd1;
  localparam logic [2:0] S_LEN1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  // Modulo-256 running sum of payload bytes.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/rom_stream_loader_if.sv
// Byte-stream input and ROM write port of the loader, bundled as one interface.
interface rom_stream_loader_if #(
  parameter int ADDR_W = 12
) ();

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_wdata;

  // master: byte source and ROM; slave: the loader itself
  modport master (
    output rx_valid, rx_data,
    input  rx_ready, rom_we, rom_addr, rom_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, rom_we, rom_addr, rom_wdata
  );

endinterface

// File: rtl/rom_stream_loader_word_pack.sv
// Little-endian byte-to-word packer with byte counter and payload checksum.
// o_word/o_word_done present the completed word in the cycle of the 4th byte.
module loader_word_pack
  import rom_stream_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_byte_vld,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_done,
  output logic [7:0]  o_csum
);

  logic [31:0] r_shift;
  logic [1:0]  r_cnt;
  logic [7:0]  r_csum;
  logic [31:0] w_word;

  assign w_word      = {i_byte, r_shift[31:8]};
  assign o_word      = w_word;
  assign o_word_done = i_byte_vld && (r_cnt == 2'd3);
  assign o_csum      = r_csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_csum  <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_csum  <= '0;
    end else if (i_byte_vld) begin
      r_shift <= w_word;
      r_cnt   <= r_cnt + 2'd1;
      r_csum  <= csum_add(r_csum, i_byte);
    end
  end

endmodule

// File: rtl/rom_stream_loader.sv
// Boot loader: parses MAGIC/LEN/payload/CSUM frames, writes words to ROM from
// address 0 and releases the core only after a checksum-valid image.
module rom_stream_loader
  import rom_stream_loader_pkg::*;
#(
  parameter int         ADDR_W  = 12,
  parameter int         TIMEOUT = 100000,
  parameter logic [7:0] MAGIC   = MAGIC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  rom_stream_loader_if.slave bus,
  input  logic               i_rearm,
  output logic               o_core_hold,
  output logic               o_done,
  output logic               o_err
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [32:0]      LEN_MAX  = 33'd1 << ADDR_W;

  logic [2:0]        r_state;
  logic [7:0]        r_len_lo;
  logic [15:0]       r_len;
  logic [15:0]       r_word_idx;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_rom_we;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [31:0]       r_rom_wdata;
  logic              r_core_hold;
  logic              r_done;
  logic              r_err;

  logic        w_rx_ready;
  logic        w_acc;
  logic        w_frame_start;
  logic        w_clear;
  logic        w_data_acc;
  logic [15:0] w_len;
  logic        w_tmo_active;
  logic        w_tmo_hit;
  logic [31:0] w_word;
  logic        w_word_done;
  logic [7:0]  w_csum;

  assign w_rx_ready    = (r_state != S_DONE) && (r_state != S_ERROR);
  // rearm takes priority: a byte offered in the same cycle is dropped
  assign w_acc         = bus.rx_valid && w_rx_ready && !i_rearm;
  assign w_frame_start = w_acc && (r_state == S_IDLE) && (bus.rx_data == MAGIC);
  assign w_clear       = i_rearm || w_frame_start;
  assign w_data_acc    = w_acc && (r_state == S_DATA);
  assign w_len         = {bus.rx_data, r_len_lo};
  assign w_tmo_active  = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                         (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_tmo_hit     = w_tmo_active && !w_acc && (r_tmo == TMO_LAST);

  loader_word_pack u_pack (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_byte_vld  (w_data_acc),
    .i_byte      (bus.rx_data),
    .o_word      (w_word),
    .o_word_done (w_word_done),
    .o_csum      (w_csum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_len_lo    <= '0;
      r_len       <= '0;
      r_word_idx  <= '0;
      r_tmo       <= '0;
      r_rom_we    <= 1'b0;
      r_rom_addr  <= '0;
      r_rom_wdata <= '0;
      r_core_hold <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rom_we <= 1'b0;
      if (i_rearm) begin
        r_state     <= S_IDLE;
        r_len_lo    <= '0;
        r_len       <= '0;
        r_word_idx  <= '0;
        r_tmo       <= '0;
        r_core_hold <= 1'b1;
        r_done      <= 1'b0;
        r_err       <= 1'b0;
      end else begin
        if (w_tmo_active)
          r_tmo <= w_acc ? '0 : r_tmo + TMO_W'(1);
        if (w_word_done) begin
          r_rom_we    <= 1'b1;
          r_rom_addr  <= ADDR_W'(r_word_idx);
          r_rom_wdata <= w_word;
          r_word_idx  <= r_word_idx + 16'd1;
        end
        if (w_tmo_hit) begin
          r_state <= S_ERROR;
          r_err   <= 1'b1;
        end else if (w_acc) begin
          case (r_state)
            S_IDLE: begin
              if (w_frame_start) begin
                r_state    <= S_LEN0;
                r_word_idx <= '0;
                r_tmo      <= '0;
              end
            end
            S_LEN0: begin
              r_len_lo <= bus.rx_data;
              r_state  <= S_LEN1;
            end
            S_LEN1: begin
              r_len <= w_len;
              if ({17'd0, w_len} > LEN_MAX) begin
                r_state <= S_ERROR;
                r_err   <= 1'b1;
              end else if (w_len == 16'd0) begin
                r_state <= S_CSUM;
              end else begin
                r_state <= S_DATA;
              end
            end
            S_DATA: begin
              if (w_word_done && (r_word_idx + 16'd1 == r_len))
                r_state <= S_CSUM;
            end
            S_CSUM: begin
              if (bus.rx_data == w_csum) begin
                r_state     <= S_DONE;
                r_done      <= 1'b1;
                r_core_hold <= 1'b0;
              end else begin
                r_state <= S_ERROR;
                r_err   <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.rx_ready  = w_rx_ready;
  assign bus.rom_we    = r_rom_we;
  assign bus.rom_addr  = r_rom_addr;
  assign bus.rom_wdata = r_rom_wdata;
  assign o_core_hold   = r_core_hold;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_rom_stream_loader.sv
// Scoreboard bench for rom_stream_loader: directed frames push expected ROM
// writes; a negedge monitor pops and compares each rom_we pulse.
`timescale 1ns/1ps
module tb_rom_stream_loader;

  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 40;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rearm = 1'b0;
  logic core_hold, done, err;

  int  n_checks = 0;
  int  n_errors = 0;
  wr_t sb[$];
  wr_t exp_wr;

  logic [7:0] good [12] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00,
                            8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};

  rom_stream_loader_if #(.ADDR_W(ADDR_W)) bus ();

  rom_stream_loader #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT),
    .MAGIC   (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .i_rearm     (rearm),
    .o_core_hold (core_hold),
    .o_done      (done),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic wr_t mk_wr(input int a, input logic [31:0] d);
    wr_t w;
    w.addr = ADDR_W'(a);
    w.data = d;
    return w;
  endfunction

  // Monitor: every ROM write must match the next expected entry, and must
  // never be seen while done is already high.
  always @(negedge clk) begin
    if (!rst && bus.rom_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%08h, expected no write",
                 bus.rom_addr, bus.rom_wdata);
      end else begin
        exp_wr = sb.pop_front();
        chk("rom_addr", 32'(bus.rom_addr), 32'(exp_wr.addr));
        chk("rom_wdata", bus.rom_wdata, exp_wr.data);
        chk("write_before_done", 32'(done), 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_good(input logic [7:0] last);
    for (int i = 0; i < 11; i++) send_byte(good[i]);
    send_byte(last);
    bus.rx_valid = 1'b0;
  endtask

  task automatic push_good();
    sb.push_back(mk_wr(0, 32'h0000_0013));
    sb.push_back(mk_wr(1, 32'h0010_0093));
  endtask

  task automatic do_rearm();
    rearm = 1'b1;
    @(posedge clk);
    #1;
    rearm = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_err"}, 32'(err), 32'(e));
    chk({tag, "_core_hold"}, 32'(core_hold), 32'(h));
  endtask

  task automatic check_reset_values(input string tag);
    check_status(tag, 1'b0, 1'b0, 1'b1);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
    chk({tag, "_rom_we"}, 32'(bus.rom_we), 32'd0);
    chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
    chk({tag, "_rom_wdata"}, bus.rom_wdata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    idle(2);

    // Good two-word load
    push_good();
    send_good(8'hB6);
    idle(2);
    check_status("good", 1'b1, 1'b0, 1'b0);
    chk("good_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("good_sb_empty", 32'(sb.size()), 32'd0);

    do_rearm();
    check_status("rearm", 1'b0, 1'b0, 1'b1);
    chk("rearm_rx_ready", 32'(bus.rx_ready), 32'd1);

    // Bad checksum: words still written, load rejected
    push_good();
    send_good(8'hB7);
    idle(2);
    check_status("badcsum", 1'b0, 1'b1, 1'b1);
    chk("badcsum_sb_empty", 32'(sb.size()), 32'd0);
    do_rearm();

    // Garbage before the frame is ignored
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    push_good();
    send_good(8'hB6);
    idle(2);
    check_status("garbage", 1'b1, 1'b0, 1'b0);
    chk("garbage_sb_empty", 32'(sb.size()), 32'd0);
    do_rearm();

    // Zero-length frame
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(2);
    check_status("zerolen", 1'b1, 1'b0, 1'b0);
    do_rearm();

    // Oversize length 4097 errors right after the high length byte
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    bus.rx_valid = 1'b0;
    check_status("oversize", 1'b0, 1'b1, 1'b1);
    do_rearm();

    // Timeout after a partial word
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    bus.rx_valid = 1'b0;
    n = 0;
    while (err !== 1'b1 && n < TIMEOUT + 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'(TIMEOUT));
    check_status("timeout", 1'b0, 1'b1, 1'b1);
    idle(3);
    chk("timeout_sb_empty", 32'(sb.size()), 32'd0);
    do_rearm();

    // Asynchronous reset in the middle of DATA, then a clean reload
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_values("midreset");
    #3;
    rst = 1'b0;
    idle(2);
    push_good();
    send_good(8'hB6);
    idle(2);
    check_status("reload", 1'b1, 1'b0, 1'b0);

    idle(3);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
